// File: rtl/pool_pkg.sv
// Shared types and sizing for the pooling result writer: lane count, widths and the lane FIFO entry.
package pool_pkg;

  localparam int POOL_NUM      = 16;
  localparam int DATA_WIDTH    = 8;
  localparam int ADDRESS_WIDTH = 10;
  localparam int LANE_ID_WIDTH = $clog2(POOL_NUM);
  localparam int FIFO_DEPTH    = 4;
  localparam int WR_ADDR_WIDTH = LANE_ID_WIDTH + ADDRESS_WIDTH;

  typedef struct packed {
    logic                     last;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    result;
  } pool_entry_t;

endpackage

// File: rtl/pool_result_writer_if.sv
// Pool stream in, output-buffer write port out; master = pooling array side, slave = writer.
interface pool_result_writer_if;
  import pool_pkg::*;

  logic [POOL_NUM-1:0]                    pool_valid_i;
  logic [POOL_NUM-1:0]                    pool_last_i;
  logic [POOL_NUM-1:0][DATA_WIDTH-1:0]    pool_result_i;
  logic [POOL_NUM-1:0][ADDRESS_WIDTH-1:0] pool_result_address_i;
  logic                                   buf_wr_en_o;
  logic [WR_ADDR_WIDTH-1:0]               buf_wr_addr_o;
  logic [DATA_WIDTH-1:0]                  buf_wr_data_o;
  logic                                   done_o;
  logic                                   ovf_o;

  modport slave (
    input  pool_valid_i, pool_last_i, pool_result_i, pool_result_address_i,
    output buf_wr_en_o, buf_wr_addr_o, buf_wr_data_o, done_o, ovf_o
  );

  modport master (
    output pool_valid_i, pool_last_i, pool_result_i, pool_result_address_i,
    input  buf_wr_en_o, buf_wr_addr_o, buf_wr_data_o, done_o, ovf_o
  );

endinterface

// File: rtl/pool_lane_fifo.sv
// Per-lane synchronous FIFO of pool entries; a push on a full FIFO is dropped unless a pop happens the same cycle.
module pool_lane_fifo
  import pool_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  pool_entry_t din,
  output pool_entry_t dout,
  output logic        full,
  output logic        empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  pool_entry_t      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pool_result_writer.sv
// Buffers 16 pooling lanes and serialises them round-robin onto one output-buffer write port.
// Define POOL_WR_OVF_CHK_EN to build the sticky overflow detector; otherwise ovf_o is tied low.
module pool_result_writer
  import pool_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  pool_result_writer_if.slave  bus
);

  logic [POOL_NUM-1:0]      push;
  logic [POOL_NUM-1:0]      pop;
  logic [POOL_NUM-1:0]      full;
  logic [POOL_NUM-1:0]      empty;
  pool_entry_t              entry_in  [POOL_NUM];
  pool_entry_t              entry_out [POOL_NUM];

  logic [LANE_ID_WIDTH-1:0] rr_ptr;
  logic [LANE_ID_WIDTH-1:0] scan_idx;
  logic [LANE_ID_WIDTH-1:0] grant_lane_p0;
  logic                     vld_p0;
  pool_entry_t              grant_entry_p0;
  logic [POOL_NUM-1:0]      lane_done;
  logic [POOL_NUM-1:0]      done_set_p0;
  logic                     frame_done_p0;

  logic                     vld_p1;
  logic                     done_p1;
  logic [WR_ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0]    data_p1;

  for (genvar k = 0; k < POOL_NUM; k++) begin : g_lane
    assign push[k]     = bus.pool_valid_i[k];
    assign entry_in[k] = '{last:    bus.pool_last_i[k],
                           address: bus.pool_result_address_i[k],
                           result:  bus.pool_result_i[k]};

    pool_lane_fifo u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .pop   (pop[k]),
      .din   (entry_in[k]),
      .dout  (entry_out[k]),
      .full  (full[k]),
      .empty (empty[k])
    );
  end

  // Stage p0: round-robin scan starting at rr_ptr; lane index wraps by truncation.
  always_comb begin
    vld_p0        = 1'b0;
    grant_lane_p0 = '0;
    scan_idx      = '0;
    for (int i = 0; i < POOL_NUM; i++) begin
      scan_idx = rr_ptr + LANE_ID_WIDTH'(i);
      if (!vld_p0 && !empty[scan_idx]) begin
        vld_p0        = 1'b1;
        grant_lane_p0 = scan_idx;
      end
    end
  end

  assign pop            = vld_p0 ? (POOL_NUM'(1) << grant_lane_p0) : '0;
  assign grant_entry_p0 = entry_out[grant_lane_p0];
  assign done_set_p0    = lane_done | ((vld_p0 && grant_entry_p0.last) ? pop : '0);
  assign frame_done_p0  = vld_p0 && grant_entry_p0.last && (&done_set_p0);

  // Stage p1: registered write port, frame tracking and arbiter pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1    <= 1'b0;
      done_p1   <= 1'b0;
      addr_p1   <= '0;
      data_p1   <= '0;
      rr_ptr    <= '0;
      lane_done <= '0;
    end else begin
      vld_p1  <= vld_p0;
      done_p1 <= frame_done_p0;
      if (vld_p0) begin
        rr_ptr    <= grant_lane_p0 + 1'b1;
        addr_p1   <= {grant_lane_p0, grant_entry_p0.address};
        data_p1   <= grant_entry_p0.result;
        lane_done <= frame_done_p0 ? '0 : done_set_p0;
      end
    end
  end

  assign bus.buf_wr_en_o   = vld_p1;
  assign bus.buf_wr_addr_o = addr_p1;
  assign bus.buf_wr_data_o = data_p1;
  assign bus.done_o        = done_p1;

`ifdef POOL_WR_OVF_CHK_EN
  logic ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       ovf <= 1'b0;
    else if (|(push & full & ~pop)) ovf <= 1'b1;
  end

  assign bus.ovf_o = ovf;
`else
  logic unused_full;
  assign unused_full = ^full;
  assign bus.ovf_o   = 1'b0;
`endif

endmodule

// File: tb/tb_pool_result_writer.sv
// Directed bench for pool_result_writer: scoreboard of expected writes checked by a negedge monitor.
module tb_pool_result_writer;
  import pool_pkg::*;

  typedef struct {
    logic [WR_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
    logic                     done;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];
  bit   exp_ovf;

  always #5 clk = ~clk;

  pool_result_writer_if bus ();

  pool_result_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.pool_valid_i          = '0;
    bus.pool_last_i           = '0;
    bus.pool_result_i         = '0;
    bus.pool_result_address_i = '0;
  endtask

  task automatic drv(input int lane, input int a, input int d, input bit last);
    bus.pool_valid_i[lane]          = 1'b1;
    bus.pool_last_i[lane]           = last;
    bus.pool_result_i[lane]         = DATA_WIDTH'(d);
    bus.pool_result_address_i[lane] = ADDRESS_WIDTH'(a);
  endtask

  task automatic exp_wr(input int lane, input int a, input int d, input bit dn);
    exp_t e;
    e.addr = {LANE_ID_WIDTH'(lane), ADDRESS_WIDTH'(a)};
    e.data = DATA_WIDTH'(d);
    e.done = dn;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && sb.size() > 0; i++) tick();
    chk(tag, sb.size(), 0);
    repeat (3) tick();
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.buf_wr_en_o === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", bus.buf_wr_en_o, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wr_addr", bus.buf_wr_addr_o, e.addr);
          chk("wr_data", bus.buf_wr_data_o, e.data);
          chk("wr_done", bus.done_o, e.done);
        end
      end else begin
        chk("idle_done", bus.done_o, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
`ifdef POOL_WR_OVF_CHK_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    rst = 1'b0;
    clear_in();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rst_wr_en", bus.buf_wr_en_o, 0);
    chk("rst_wr_addr", bus.buf_wr_addr_o, 0);
    chk("rst_wr_data", bus.buf_wr_data_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_ovf", bus.ovf_o, 0);

    // Contention from rr_ptr=0: grants 0, 5, 15.
    drv(0, 'h010, 'hA0, 0);
    drv(5, 'h055, 'hA5, 0);
    drv(15, 'h3FF, 'hAF, 0);
    exp_wr(0, 'h010, 'hA0, 0);
    exp_wr(5, 'h055, 'hA5, 0);
    exp_wr(15, 'h3FF, 'hAF, 0);
    tick();
    clear_in();
    drain("drain_contention");

    // Two frames; each lane sends two results, the second marked last.
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < POOL_NUM; k++) begin
        drv(k, 'h100 + k, (f << 6) | k, 0);
        exp_wr(k, 'h100 + k, (f << 6) | k, 0);
      end
      tick();
      for (int k = 0; k < POOL_NUM; k++) begin
        drv(k, 'h200 + k, 'h80 | (f << 6) | k, 1);
        exp_wr(k, 'h200 + k, 'h80 | (f << 6) | k, k == POOL_NUM - 1);
      end
      tick();
      clear_in();
      drain("drain_frame");
    end

    // Fairness: lanes 2 and 9 loaded together three times; rr_ptr=0 after frames.
    for (int c = 0; c < 3; c++) begin
      drv(2, 'h020 + c, 'h21 + c, 0);
      drv(9, 'h090 + c, 'h91 + c, 0);
      exp_wr(2, 'h020 + c, 'h21 + c, 0);
      exp_wr(9, 'h090 + c, 'h91 + c, 0);
      tick();
    end
    clear_in();
    drain("drain_fair");
    chk("ovf_before", bus.ovf_o, 0);

    // Overflow: rr_ptr=10; lanes 10..15 occupy the arbiter while lane 1 pushes 5 entries.
    for (int k = 10; k < 16; k++) begin
      drv(k, 'h0A0 + k, 'h30 + k, 0);
      exp_wr(k, 'h0A0 + k, 'h30 + k, 0);
    end
    for (int c = 0; c < 5; c++) begin
      drv(1, 'h001 + c, 'h11 + c, 0);
      if (c < 4) exp_wr(1, 'h001 + c, 'h11 + c, 0);
      tick();
      clear_in();
    end
    drain("drain_ovf");
    chk("ovf_after", bus.ovf_o, exp_ovf);

    // Reset mid-frame with three entries buffered.
    drv(10, 'h00A, 'hCA, 0);
    drv(11, 'h00B, 'hCB, 0);
    drv(12, 'h00C, 'hCC, 1);
    tick();
    clear_in();
    rst = 1'b0;
    #1;
    chk("mid_rst_wr_en", bus.buf_wr_en_o, 0);
    chk("mid_rst_wr_addr", bus.buf_wr_addr_o, 0);
    chk("mid_rst_wr_data", bus.buf_wr_data_o, 0);
    chk("mid_rst_ovf", bus.ovf_o, 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (6) tick();
    chk("post_rst_idle", bus.buf_wr_en_o, 0);

    // Single lane latency: valid sampled at edge E, write visible after E+1.
    drv(3, 'h005, 'h7A, 0);
    exp_wr(3, 'h005, 'h7A, 0);
    tick();
    clear_in();
    chk("lat_e0_wr_en", bus.buf_wr_en_o, 0);
    tick();
    chk("lat_e1_wr_en", bus.buf_wr_en_o, 1);
    chk("lat_e1_wr_addr", bus.buf_wr_addr_o, 'h0C05);
    chk("lat_e1_wr_data", bus.buf_wr_data_o, 'h7A);
    drain("drain_single");
    chk("single_no_more", bus.buf_wr_en_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
